// File: rtl/miner_pkg.sv
// Shared definitions for the solver work controller.
//   - Solver state codes as reported on the solver's state_out.
//   - Status codes sent as the first byte of a result packet.
//   - Packet sizes and the controller state enum.
//   - Helpers that classify a solver state and map it to a status byte.
package miner_pkg;

    localparam int WORK_BYTES   = 76;  // 32 midstate + 12 header leftovers + 32 target
    localparam int RESULT_BYTES = 5;   // 1 status + 4 nonce
    localparam int WORK_BITS    = WORK_BYTES * 8;

    typedef enum logic [2:0] {
        WORKING_PRE        = 3'd0,
        WORKING            = 3'd1,
        WORKING_SECOND_PRE = 3'd2,
        WORKING_SECOND     = 3'd3,
        SOLUTION_FOUND     = 3'd4,
        NO_SOLUTION        = 3'd5
    } solver_state_e;

    localparam logic [7:0] ST_FOUND     = 8'h01;
    localparam logic [7:0] ST_EXHAUSTED = 8'h02;
    localparam logic [7:0] ST_FAULT     = 8'h03;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        RUN    = 2'd1,
        RESULT = 2'd2
    } ctrl_state_e;

    // Codes 4..7 end a run; 6 and 7 are not defined by the solver and are
    // reported as a fault rather than ignored.
    function automatic logic is_terminal(input logic [2:0] code);
        return code >= 3'(SOLUTION_FOUND);
    endfunction

    function automatic logic [7:0] status_for(input logic [2:0] code);
        logic [7:0] st;
        case (code)
            3'(SOLUTION_FOUND): st = ST_FOUND;
            3'(NO_SOLUTION):    st = ST_EXHAUSTED;
            default:            st = ST_FAULT;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/work_controller_result_serializer.sv
// result_serializer: latches a status byte and a 32-bit nonce on a load
// strobe and transmits them as a 5-byte valid/ready stream
// (status, nonce[31:24], nonce[23:16], nonce[15:8], nonce[7:0]).
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   load               one-cycle strobe; captures status_in/nonce_in
//   status_in[7:0]     status byte to send first
//   nonce_in[31:0]     nonce to send big-endian after the status
//   out_data[7:0]      current byte, registered, stable until consumed
//   out_valid          out_data valid
//   out_ready          sink accepts when out_valid && out_ready
//   done               combinational pulse on the handshake of the last byte
module result_serializer
    import miner_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [7:0]  status_in,
    input  logic [31:0] nonce_in,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        done
);

    localparam logic [2:0] LAST_IDX = 3'(RESULT_BYTES - 1);

    logic [7:0]  status_q, status_d;
    logic [31:0] nonce_q, nonce_d;
    logic [2:0]  tx_cnt_q, tx_cnt_d;
    logic        valid_q, valid_d;
    logic [7:0]  data_q, data_d;
    logic        handshake;

    function automatic logic [7:0] pick_byte(input logic [2:0] idx,
                                             input logic [7:0] st,
                                             input logic [31:0] n);
        logic [7:0] b;
        case (idx)
            3'd0:    b = st;
            3'd1:    b = n[31:24];
            3'd2:    b = n[23:16];
            3'd3:    b = n[15:8];
            default: b = n[7:0];
        endcase
        return b;
    endfunction

    assign handshake = valid_q && out_ready;

    always_comb begin
        status_d = status_q;
        nonce_d  = nonce_q;
        tx_cnt_d = tx_cnt_q;
        valid_d  = valid_q;
        data_d   = data_q;
        done     = 1'b0;
        if (load) begin
            status_d = status_in;
            nonce_d  = nonce_in;
            tx_cnt_d = 3'd0;
            valid_d  = 1'b1;
            data_d   = status_in;
        end else if (handshake) begin
            if (tx_cnt_q == LAST_IDX) begin
                valid_d = 1'b0;
                done    = 1'b1;
            end else begin
                // Present the next byte from the edge that consumes the
                // current one, so a held-high out_ready streams one per cycle.
                tx_cnt_d = tx_cnt_q + 3'd1;
                data_d   = pick_byte(tx_cnt_q + 3'd1, status_q, nonce_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
            nonce_q  <= '0;
            tx_cnt_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            status_q <= status_d;
            nonce_q  <= nonce_d;
            tx_cnt_q <= tx_cnt_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/work_controller.sv
// work_controller: host-facing front/back end for one block solver.
// Loads a 76-byte work packet from a byte stream into a 608-bit shift
// register, releases the solver from reset while it runs, and reports the
// outcome as a 5-byte result packet.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_data/in_valid/in_ready   work byte stream (ready only while loading)
//   out_data/out_valid/out_ready result byte stream
//   midstate[255:0]          first 32 bytes received (first byte at [255:248])
//   header_leftovers[95:0]   next 12 bytes
//   target[255:0]            last 32 bytes
//   solver_rst_n             solver reset, high only while running
//   solver_state[2:0]        solver state_out
//   solver_nonce[31:0]       solver nonce, latched when a run ends
//   busy                     high while running
module work_controller
    import miner_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] midstate,
    output logic [95:0]  header_leftovers,
    output logic [255:0] target,
    output logic         solver_rst_n,
    input  logic [2:0]   solver_state,
    input  logic [31:0]  solver_nonce,
    output logic         busy
);

    localparam logic [6:0] LAST_BYTE = 7'(WORK_BYTES - 1);

    ctrl_state_e          state_q, state_d;
    logic [WORK_BITS-1:0] shift_q, shift_d;
    logic [6:0]           byte_cnt_q, byte_cnt_d;
    logic                 in_ready_q, in_ready_d;
    logic                 solver_rst_n_q, solver_rst_n_d;
    logic                 busy_q, busy_d;

    logic                 accept;
    logic                 ser_load;
    logic [7:0]           ser_status;
    logic                 ser_done;

    // in_ready_q is only ever high in LOAD, so it also gates acceptance and
    // keeps bytes offered in other states unconsumed.
    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        ser_load   = 1'b0;
        ser_status = ST_FAULT;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    shift_d = {shift_q[WORK_BITS-9:0], in_data};
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        state_d    = RUN;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 7'd1;
                    end
                end
            end
            RUN: begin
                if (is_terminal(solver_state)) begin
                    ser_load   = 1'b1;
                    ser_status = status_for(solver_state);
                    state_d    = RESULT;
                end
            end
            RESULT: begin
                if (ser_done) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
        // Outputs are registered from the next state so they line up with it.
        // The solver only leaves reset once all 76 bytes are in place.
        in_ready_d     = (state_d == LOAD);
        solver_rst_n_d = (state_d == RUN);
        busy_d         = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= LOAD;
            shift_q        <= '0;
            byte_cnt_q     <= '0;
            in_ready_q     <= 1'b0;
            solver_rst_n_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            byte_cnt_q     <= byte_cnt_d;
            in_ready_q     <= in_ready_d;
            solver_rst_n_q <= solver_rst_n_d;
            busy_q         <= busy_d;
        end
    end

    result_serializer u_result_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ser_load),
        .status_in (ser_status),
        .nonce_in  (solver_nonce),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (ser_done)
    );

    assign in_ready         = in_ready_q;
    assign solver_rst_n     = solver_rst_n_q;
    assign busy             = busy_q;
    assign midstate         = shift_q[607:352];
    assign header_leftovers = shift_q[351:256];
    assign target           = shift_q[255:0];

endmodule

// File: tb/tb_work_controller.sv
// Self-checking bench for work_controller: a packet-level reference model
// (byte window + result byte queue) is compared with the DUT every cycle,
// alongside literal expectations for the directed scenarios.
module tb_work_controller;
    import miner_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [255:0] midstate;
    logic [95:0]  header_leftovers;
    logic [255:0] target;
    logic         solver_rst_n;
    logic [2:0]   solver_state = '0;
    logic [31:0]  solver_nonce = '0;
    logic         busy;

    int chk_cnt = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    work_controller dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .midstate         (midstate),
        .header_leftovers (header_leftovers),
        .target           (target),
        .solver_rst_n     (solver_rst_n),
        .solver_state     (solver_state),
        .solver_nonce     (solver_nonce),
        .busy             (busy)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic fail_timeout(input string name);
        chk_cnt++;
        $display("FAIL %s: no handshake within bound", name);
    endtask

    // ---------------- reference model ----------------
    localparam int M_LOAD = 0, M_RUN = 1, M_RESULT = 2;
    int         m_mode = M_LOAD;
    bit         m_ready = 1'b0;
    bit         m_fresh = 1'b1;   // no result sent since reset: out_data still 0
    int         m_cnt = 0;
    logic [7:0] m_win [WORK_BYTES];  // last 76 bytes, [0] oldest, zero-filled
    logic [7:0] m_res [$];           // bytes of the packet still to be sent

    function automatic logic [255:0] win_field(input int first, input int nbytes);
        logic [255:0] v = '0;
        for (int i = 0; i < nbytes; i++) v = {v[247:0], m_win[first + i]};
        return v;
    endfunction

    task automatic model_reset();
        m_mode = M_LOAD; m_ready = 1'b0; m_fresh = 1'b1; m_cnt = 0;
        for (int i = 0; i < WORK_BYTES; i++) m_win[i] = '0;
        m_res.delete();
    endtask

    task automatic model_step();
        logic [7:0] st;
        if (!rst_n) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_LOAD: if (in_valid && m_ready) begin
                for (int i = 0; i < WORK_BYTES - 1; i++) m_win[i] = m_win[i + 1];
                m_win[WORK_BYTES - 1] = in_data;
                m_cnt++;
                if (m_cnt == WORK_BYTES) begin m_cnt = 0; m_mode = M_RUN; end
            end
            M_RUN: if (solver_state >= 3'd4) begin
                st = (solver_state == 3'd4) ? 8'h01 : (solver_state == 3'd5) ? 8'h02 : 8'h03;
                m_res.delete();
                m_res.push_back(st);
                m_res.push_back(solver_nonce[31:24]);
                m_res.push_back(solver_nonce[23:16]);
                m_res.push_back(solver_nonce[15:8]);
                m_res.push_back(solver_nonce[7:0]);
                m_mode = M_RESULT;
                m_fresh = 1'b0;
            end
            default: if (out_ready) begin
                void'(m_res.pop_front());
                if (m_res.size() == 0) m_mode = M_LOAD;
            end
        endcase
        m_ready = (m_mode == M_LOAD);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("in_ready", in_ready, m_ready);
            chk("out_valid", out_valid, m_mode == M_RESULT);
            chk("solver_rst_n", solver_rst_n, m_mode == M_RUN);
            chk("busy", busy, m_mode == M_RUN);
            if (m_mode == M_RESULT) chk("out_data", out_data, m_res[0]);
            else if (m_fresh) chk("out_data idle", out_data, 8'h00);
            chk("midstate", midstate, win_field(0, 32));
            chk("header_leftovers", header_leftovers, win_field(32, 12));
            chk("target", target, win_field(44, 32));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    // n bytes: sequential from base when seq, else random; optional random gaps.
    // The solver state is junk while loading; it must be ignored there.
    task automatic send_bytes(input int n, input bit seq, input logic [7:0] base, input bit gaps);
        int guard;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    in_valid = 1'b0; in_data = 8'($urandom); solver_state = 3'($urandom);
                    tick();
                end
            end
            in_valid = 1'b1;
            in_data = seq ? base + 8'(i) : 8'($urandom);
            solver_state = 3'($urandom);
            guard = 0;
            while (!in_ready && guard < 100) begin tick(); guard++; end
            if (!in_ready) fail_timeout("in_ready wait");
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic hold_run(input int n, input bit offer_aa);
        chk("busy entering run", busy, 1'b1);
        for (int i = 0; i < n; i++) begin
            solver_state = 3'($urandom_range(0, 3));
            solver_nonce = $urandom;
            in_valid = offer_aa;
            in_data = 8'hAA;
            tick();
        end
    endtask

    task automatic finish_run(input logic [2:0] term, input logic [31:0] nonce);
        solver_state = term;
        solver_nonce = nonce;
        tick();
        in_valid = 1'b0;
        solver_state = 3'($urandom);
        solver_nonce = $urandom;
    endtask

    task automatic collect(input logic [39:0] exp, input bit rnd);
        logic [7:0] got [RESULT_BYTES];
        int n = 0;
        int guard = 0;
        bit first = 1'b1;
        while (n < RESULT_BYTES && guard < 200) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid) begin
                if (first) begin chk("solver_rst_n at first out_valid", solver_rst_n, 1'b0); first = 1'b0; end
                if (out_ready) begin got[n] = out_data; n++; end
            end
            tick();
            guard++;
        end
        out_ready = 1'b0;
        if (n < RESULT_BYTES) fail_timeout("result bytes");
        for (int i = 0; i < n; i++)
            chk($sformatf("result byte %0d", i), got[i], exp[39 - 8*i -: 8]);
        chk("in_ready after result", in_ready, 1'b1);
        chk("out_valid after result", out_valid, 1'b0);
    endtask

    initial begin
        logic [2:0]  term;
        logic [31:0] nonce;
        logic [7:0]  st;

        // Reset with inputs at 0.
        repeat (3) tick();
        chk("reset in_ready", in_ready, 1'b0);
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset out_data", out_data, 8'h00);
        chk("reset solver_rst_n", solver_rst_n, 1'b0);
        chk("reset busy", busy, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("in_ready after reset", in_ready, 1'b1);

        // Back-to-back 0x00..0x4B.
        send_bytes(WORK_BYTES, 1'b1, 8'h00, 1'b0);
        chk("midstate seq", midstate, 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F);
        chk("header seq", header_leftovers, 96'h202122232425262728292A2B);
        chk("target seq", target, 256'h2C2D2E2F303132333435363738393A3B3C3D3E3F404142434445464748494A4B);
        chk("solver_rst_n 1 cycle after last byte", solver_rst_n, 1'b1);

        // 50 running cycles with 0xAA offered, then SOLUTION_FOUND.
        hold_run(50, 1'b1);
        chk("midstate held in run", midstate, 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F);
        chk("in_ready in run", in_ready, 1'b0);
        finish_run(3'd4, 32'h0000_1234);
        collect(40'h01_0000_1234, 1'b0);

        // NO_SOLUTION with throttled sink.
        send_bytes(WORK_BYTES, 1'b0, 8'h00, 1'b1);
        hold_run(10, 1'b0);
        finish_run(3'd5, 32'hFFFF_FFFF);
        collect(40'h02_FFFF_FFFF, 1'b1);

        // Reset in the middle of a run.
        send_bytes(WORK_BYTES, 1'b0, 8'h00, 1'b1);
        hold_run(20, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("solver_rst_n on async reset", solver_rst_n, 1'b0);
        chk("busy on async reset", busy, 1'b0);
        chk("midstate on async reset", midstate, 256'h0);
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("in_ready after mid-run reset", in_ready, 1'b1);
        send_bytes(10, 1'b1, 8'hC0, 1'b0);
        chk("partial target", target[79:0], 80'hC0C1C2C3C4C5C6C7C8C9);
        chk("partial midstate", midstate, 256'h0);
        repeat (30) tick();
        chk("partial pending busy", busy, 1'b0);
        chk("partial pending solver_rst_n", solver_rst_n, 1'b0);
        send_bytes(WORK_BYTES - 10, 1'b0, 8'h00, 1'b1);
        hold_run(5, 1'b0);
        finish_run(3'd6, 32'h0000_ABCD);
        collect(40'h03_0000_ABCD, 1'b1);

        // Random runs.
        for (int k = 0; k < 4; k++) begin
            term = 3'($urandom_range(4, 7));
            nonce = $urandom;
            st = (term == 3'd4) ? 8'h01 : (term == 3'd5) ? 8'h02 : 8'h03;
            send_bytes(WORK_BYTES, 1'b0, 8'h00, 1'b1);
            hold_run($urandom_range(1, 20), 1'($urandom_range(0, 1)));
            finish_run(term, nonce);
            collect({st, nonce}, 1'($urandom_range(0, 1)));
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/work_controller.md
Name: work_controller

Overview:
- Host-facing front/back end for the block solver.
- Receives a 76-byte work packet (midstate, header leftovers, target) over a byte stream and drives the solver's work inputs.
- Holds the solver in reset except while running, watches the solver state, and returns a 5-byte result packet (status + nonce) over a byte stream.
- Sits between the host UART/bridge and one solver instance.

Parameters:
- WORK_BYTES, 76, bytes per work packet: 32 midstate + 12 header leftovers + 32 target.
- RESULT_BYTES, 5, bytes per result packet: 1 status + 4 nonce.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- in_data  in  8  work byte
- in_valid  in  1  in_data valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- out_data  out  8  result byte
- out_valid  out  1  out_data valid
- out_ready  in  1  byte consumed when out_valid && out_ready
- midstate  out  256  to solver
- header_leftovers  out  96  to solver
- target  out  256  to solver
- solver_rst_n  out  1  to solver rst_n; solver's reset is synchronous
- solver_state  in  3  solver state_out
- solver_nonce  in  32  solver nonce
- busy  out  1  high in RUN

Behaviour:
- Reset (async, rst_n=0): state=LOAD, byte_cnt=0, 608-bit shift reg=0, in_ready=0 during reset, out_valid=0, out_data=0, solver_rst_n=0, busy=0, nonce latch=0, status=0.
- Work register:
  - On each accepted byte: shift reg <= {shift[599:0], in_data}.
  - midstate=shift[607:352], header_leftovers=shift[351:256], target=shift[255:0].
  - First byte received lands in midstate[255:248].
- LOAD:
  - in_ready=1, solver_rst_n=0.
  - byte_cnt counts 0..75.
  - Accepting byte 75: byte_cnt <= 0, state <= RUN next cycle. No idle cycle.
  - The minimum of 76 cycles with solver_rst_n=0 guarantees the solver has been synchronously reset into WORKING_PRE (0).
- RUN:
  - in_ready=0, solver_rst_n=1, busy=1.
  - Each cycle, sample solver_state:
    - 0..3: stay in RUN.
    - 4 (SOLUTION_FOUND): status <= 0x01.
    - 5 (NO_SOLUTION): status <= 0x02.
    - 6/7: status <= 0x03 (fault).
  - On 4..7, in the same edge: nonce_q <= solver_nonce, tx_cnt <= 0, state <= RESULT.
  - solver_rst_n drops to 0 in the first RESULT cycle. The solver is frozen and its nonce is not used after the latch.
- RESULT:
  - in_ready=0, solver_rst_n=0, out_valid=1.
  - out_data by tx_cnt: 0 → status, 1 → nonce_q[31:24], 2 → [23:16], 3 → [15:8], 4 → [7:0].
  - tx_cnt advances only on the handshake. out_data is stable while out_valid && !out_ready.
  - Handshake on tx_cnt=4: out_valid <= 0, state <= LOAD.
  - The first in_ready=1 is the cycle after that handshake.
- Latency:
  - Last work byte → solver_rst_n=1: 1 cycle.
  - Terminal solver_state sampled → out_valid=1: 1 cycle.
- Boundaries:
  - in_valid outside LOAD is ignored and not consumed.
  - A partial packet stays pending until completed; there is no timeout.
  - Reset mid-RUN: solver_rst_n=0 immediately (async). The load restarts at byte 0 and the work register clears.
  - Reset mid-RESULT discards the packet.
  - out_ready held high gives a 5-cycle burst.
  - The solver is never released with a partially loaded work register.

Decomposition:
- Package miner_pkg:
  - solver state codes WORKING_PRE=0, WORKING=1, WORKING_SECOND_PRE=2, WORKING_SECOND=3, SOLUTION_FOUND=4, NO_SOLUTION=5;
  - status codes ST_FOUND=8'h01, ST_EXHAUSTED=8'h02, ST_FAULT=8'h03;
  - WORK_BYTES, RESULT_BYTES;
  - controller state enum LOAD/RUN/RESULT.
- One sub-module, result_serializer: latches status + nonce on a load strobe, runs the 5-byte valid/ready transmit, and pulses done.
- Load shift register and FSM stay in work_controller.

Test Plan:
- Reset with all inputs at 0 → out_valid=0, solver_rst_n=0, busy=0, in_ready=1 one cycle after rst_n rises.
- Send bytes 0x00..0x4B back-to-back → midstate=0x00010203…1E1F, header_leftovers=0x202122…2B, target=0x2C2D…4A4B; solver_rst_n=1 exactly 1 cycle after byte 0x4B handshake.
- Stub solver_state 0,1,2,3 for 50 cycles, then 4 with solver_nonce=0x00001234 → out bytes 01 00 00 12 34 with out_ready=1; solver_rst_n=0 on the first out_valid cycle; in_ready=1 after the fifth byte.
- solver_state=5, nonce=0xFFFFFFFF, out_ready toggled 1/0 randomly → bytes 02 FF FF FF FF, each held stable while out_ready=0, no byte lost or duplicated.
- in_valid=1 with data 0xAA throughout RUN → in_ready=0, work registers unchanged; then assert rst_n=0 mid-RUN → solver_rst_n=0 the same cycle; next load starts at byte 0.
- solver_state=6 in RUN with nonce 0x0000ABCD → bytes 03 00 00 AB CD.
